pcs_tx_ordered_set: RTL
=======================

// Module: pcs_tx_ordered_set
// PURPOSE
// 1000BASE-X PCS transmit ordered-set generator; sits directly upstream of the 8b/10b encoder.
// - Converts GMII txd/tx_en/tx_er and autoneg config words into a byte + K-flag stream, one code-group per clk.
// - Inserts /I/, /C/, /S/, /T/, /R/ and /V/ code-groups and keeps /S/ on even code-group positions.
// - Uses the encoder's running disparity to choose between /I1/ and /I2/.
// PARAMETERS
// CONFIG_EN  1  1: XMIT_CONFIG emits /C/ sets; 0: XMIT_CONFIG is treated as XMIT_IDLE
// PORTS
// clk            in   1   PCS clock, 125 MHz, one code-group per cycle
// reset          in   1   synchronous, active-high
// gmii_txd       in   8   GMII transmit data
// gmii_tx_en     in   1   GMII transmit enable
// gmii_tx_er     in   1   GMII transmit error
// xmit           in   2   mode: 2'b00 IDLE, 2'b01 CONFIG, 2'b10 DATA (2'b11 treated as IDLE)
// tx_config_reg  in   16  autoneg config word; [7:0] is sent first
// rd_in          in   1   encoder running disparity entering the code-group currently on tx_data (1 = RD+)
// tx_data        out  8   code-group byte to encoder
// tx_k           out  1   1 = control code-group
// tx_even        out  1   1 = the current output is an even-position code-group
// ipg_violation  out  1   one-cycle pulse: tx_en was high during the end sequence; that byte is dropped
// BEHAVIOUR
// - All outputs are registered. Reset values: tx_data=8'hBC, tx_k=1, tx_even=1, ipg_violation=0, state IDLE.
// - Code constants: K28.5=BC, K27.7=FB (/S/), K29.7=FD (/T/), K23.7=F7 (/R/), K30.7=FE (/V/);
//   D5.6=C5, D16.2=50, D21.5=B5, D2.2=42.
// - Latency: a GMII byte sampled at edge n appears on tx_data after edge n+1 (1 cycle). The latency is fixed for all cases.
// - Position: tx_even toggles every cycle and never skips. Ordered sets always start at tx_even=1.
// - IDLE set /I/:
//   - even slot = K28.5.
//   - odd slot = D5.6 (/I1/) if rd_in==1 during the K28.5 cycle, else D16.2 (/I2/).
//   - rd_in is used combinationally in that cycle's next-state logic. No extra register.
// - CONFIG set /C/ (xmit=CONFIG, CONFIG_EN=1):
//   - 4-group sets, alternating /C1/ = K28.5 D21.5 cfg_lo cfg_hi and /C2/ = K28.5 D2.2 cfg_lo cfg_hi.
//   - The first set after entering CONFIG is /C1/.
//   - tx_config_reg is captured at the K28.5 of each set and held for that set.
// - States: IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, DATA, END_T, END_R1, END_R2.
// - Frame start (xmit=DATA, gmii_tx_en rises):
//   - rise decided for an even slot: /S/ replaces the first preamble byte, then DATA.
//   - rise decided for an odd slot: the idle odd code-group is completed in place of the first preamble byte;
//     /S/ replaces the second preamble byte. The preamble shrinks by 1 and latency is unchanged.
// - DATA: each byte passes through with tx_k=0. gmii_tx_er=1 with tx_en=1 emits /V/ in place of that byte.
// - Frame end (tx_en falls):
//   - /T/ is emitted at the slot where the first tx_en=0 byte would appear, then /R/.
//   - If /R/ lands on an even slot, a second /R/ is emitted so that IDLE resumes on an even slot.
// - tx_en=1 during END_T/END_R1/END_R2: the byte is dropped and ipg_violation pulses per dropped byte.
//   If tx_en is still high at the first even IDLE slot, /S/ is emitted there and the frame continues.
// - tx_er=1 with tx_en=0 (carrier extension) is not supported and is treated as idle.
// - xmit changes:
//   - sampled only at an ordered-set boundary, i.e. the cycle before an even slot with no frame in progress.
//   - DATA->IDLE/CONFIG mid-frame: the frame is closed with /T/R/[R/] as if tx_en fell, then the new mode starts.
//   - a /C/ set in progress is always completed before the mode changes.
// - Reset mid-frame: immediate return to reset values. No /T/ is emitted. The downstream encoder is reset on the same cycle.
// STRUCTURE
// - Package pcs_8b10b_pkg:
//   - K/D code-group byte constants listed above.
//   - xmit mode localparams.
//   - state encoding.
//   - shared with encoder, decoder and RX sync.
// - Single flat module: one FSM plus tx_even toggle and a config-word holding register. No sub-module.
// TESTING
// - reset, xmit=IDLE, rd_in=0: after reset BC/K; next cycle 50; rd_in=1 at BC cycle -> C5.
// - xmit=CONFIG, cfg=16'h01A0:
//   - sequence BC B5 A0 01 BC 42 A0 01 repeats.
//   - cfg changed mid-set takes effect at the next BC.
// - xmit=DATA, tx_en rises at even slot with 55 55 55 55 55 55 55 D5 AA:
//   - output FB/K, 55x6, D5, AA, FD/K, F7/K, plus F7/K if needed for alignment, then BC on tx_even=1.
// - tx_en rises at odd slot: idle odd group, FB, 55x5, D5; total frame latency is still 1 cycle.
// - tx_er=1 on data byte 3 -> FE/K at byte 3 only.
// - tx_en reasserted 1 cycle after fall: ipg_violation=1 for the dropped byte; /S/ at the next even slot.
// - xmit DATA->CONFIG mid-frame: /T/R/ emitted, then BC B5 ...

Source files
------------

// File: rtl/pcs_8b10b_pkg.sv
// Shared 1000BASE-X PCS definitions: code-group bytes, xmit modes and the
// transmit ordered-set state encoding used by the TX, RX and encoder blocks.
package pcs_8b10b_pkg;

  // Control code-groups (sent with K flag set)
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  // Data code-groups used inside ordered sets
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  localparam logic [1:0] XMIT_IDLE   = 2'b00;
  localparam logic [1:0] XMIT_CONFIG = 2'b01;
  localparam logic [1:0] XMIT_DATA   = 2'b10;

  typedef logic [3:0] tx_state_t;

  localparam tx_state_t ST_IDLE_K = 4'd0;
  localparam tx_state_t ST_IDLE_D = 4'd1;
  localparam tx_state_t ST_CFG_K  = 4'd2;
  localparam tx_state_t ST_CFG_D  = 4'd3;
  localparam tx_state_t ST_CFG_LO = 4'd4;
  localparam tx_state_t ST_CFG_HI = 4'd5;
  localparam tx_state_t ST_DATA   = 4'd6;
  localparam tx_state_t ST_END_T  = 4'd7;
  localparam tx_state_t ST_END_R1 = 4'd8;
  localparam tx_state_t ST_END_R2 = 4'd9;

endpackage

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator: turns GMII and autoneg config
// words into a byte + K stream for the 8b/10b encoder, one code-group per clk.
module pcs_tx_ordered_set #(
  parameter bit CONFIG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  input  logic [1:0]  xmit,
  input  logic [15:0] tx_config_reg,
  input  logic        rd_in,
  output logic [7:0]  tx_data,
  output logic        tx_k,
  output logic        tx_even,
  output logic        ipg_violation
);
  import pcs_8b10b_pkg::*;

  // state names the code-group currently on tx_data
  tx_state_t   state, state_nxt;
  logic [7:0]  txd_q;
  logic        tx_en_q, tx_er_q;
  logic [15:0] cfg_hold, cfg_hold_nxt;
  logic        cfg_c2, cfg_c2_nxt;
  logic [7:0]  data_nxt;
  logic        k_nxt, ipg_nxt, at_boundary;
  logic        mode_data, mode_cfg;

  assign mode_data = (xmit == XMIT_DATA);
  assign mode_cfg  = CONFIG_EN && (xmit == XMIT_CONFIG);

  // Boundary states hand the next even slot to /S/, a new /C/ set or /I/.
  // A byte arriving while /R/ is being sent is dropped and flagged.
  always_comb begin
    state_nxt    = state;
    data_nxt     = K28_5;
    k_nxt        = 1'b1;
    ipg_nxt      = 1'b0;
    cfg_hold_nxt = cfg_hold;
    cfg_c2_nxt   = cfg_c2;
    at_boundary  = 1'b0;
    case (state)
      ST_IDLE_K: begin
        state_nxt = ST_IDLE_D;
        data_nxt  = rd_in ? D5_6 : D16_2;
        k_nxt     = 1'b0;
      end
      ST_IDLE_D: at_boundary = 1'b1;
      ST_CFG_K: begin
        state_nxt = ST_CFG_D;
        data_nxt  = cfg_c2 ? D2_2 : D21_5;
        k_nxt     = 1'b0;
      end
      ST_CFG_D: begin
        state_nxt = ST_CFG_LO;
        data_nxt  = cfg_hold[7:0];
        k_nxt     = 1'b0;
      end
      ST_CFG_LO: begin
        state_nxt = ST_CFG_HI;
        data_nxt  = cfg_hold[15:8];
        k_nxt     = 1'b0;
      end
      ST_CFG_HI: at_boundary = 1'b1;
      ST_DATA: begin
        if (!mode_data || !tx_en_q) begin
          state_nxt = ST_END_T;
          data_nxt  = K29_7;
        end else if (tx_er_q) begin
          data_nxt  = K30_7;
        end else begin
          data_nxt  = txd_q;
          k_nxt     = 1'b0;
        end
      end
      ST_END_T: begin
        state_nxt = ST_END_R1;
        data_nxt  = K23_7;
        ipg_nxt   = tx_en_q;
      end
      ST_END_R1: begin
        if (tx_even) begin
          state_nxt = ST_END_R2;
          data_nxt  = K23_7;
          ipg_nxt   = tx_en_q;
        end else begin
          at_boundary = 1'b1;
        end
      end
      ST_END_R2: at_boundary = 1'b1;
      default: state_nxt = ST_IDLE_K;
    endcase

    if (at_boundary) begin
      if (mode_data && tx_en_q) begin
        state_nxt = ST_DATA;
        data_nxt  = K27_7;
      end else if (mode_cfg) begin
        state_nxt    = ST_CFG_K;
        cfg_hold_nxt = tx_config_reg;
        cfg_c2_nxt   = (state == ST_CFG_HI) ? ~cfg_c2 : 1'b0;
      end else begin
        state_nxt = ST_IDLE_K;
      end
    end
  end

  // GMII is registered once so every byte reaches tx_data one cycle after capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE_K;
      tx_data       <= K28_5;
      tx_k          <= 1'b1;
      tx_even       <= 1'b1;
      ipg_violation <= 1'b0;
      txd_q         <= 8'h00;
      tx_en_q       <= 1'b0;
      tx_er_q       <= 1'b0;
      cfg_hold      <= 16'h0000;
      cfg_c2        <= 1'b0;
    end else begin
      state         <= state_nxt;
      tx_data       <= data_nxt;
      tx_k          <= k_nxt;
      tx_even       <= ~tx_even;
      ipg_violation <= ipg_nxt;
      txd_q         <= gmii_txd;
      tx_en_q       <= gmii_tx_en;
      tx_er_q       <= gmii_tx_er;
      cfg_hold      <= cfg_hold_nxt;
      cfg_c2        <= cfg_c2_nxt;
    end
  end

endmodule
